// File: rtl/mem_arbiter.sv
// Serialises d-fills/d-writes (priority) and i-fills onto one pipelined memory port; ARB_PERF_COUNTERS_EN adds miss counters.
// Grant one cycle after request, fill words return MEM_LATENCY after issue; clients are held off through i_stall/d_stall.
module mem_arbiter #(
  parameter int MEM_LATENCY     = 4,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        i_stall,
  output logic        d_stall,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic [15:0] i_fill_addr,
  output logic [15:0] d_fill_addr,
  output logic [15:0] i_fill_data,
  output logic [15:0] d_fill_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [15:0] i_miss_cnt,
  output logic [15:0] d_miss_cnt
);

  localparam int CW = $clog2(WORDS_PER_BLOCK) + 1;
  localparam logic [CW-1:0] NWORDS   = CW'(WORDS_PER_BLOCK);
  localparam logic [CW-1:0] LAST     = CW'(WORDS_PER_BLOCK - 1);
  localparam logic [15:0]   OFF_MASK = 16'(2 * WORDS_PER_BLOCK - 1);

  if (MEM_LATENCY < 1 || WORDS_PER_BLOCK < 2) begin : g_bad_cfg
    $error("mem_arbiter: MEM_LATENCY must be >= 1 and WORDS_PER_BLOCK >= 2");
  end

  typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, WRITE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] issue_cnt, ret_cnt;
  logic [15:0]   base, base_n;
  logic          done_d;
  logic          fill_active, issue_active, ret_fire;

  assign fill_active  = (state == FILL_I) || (state == FILL_D);
  assign issue_active = fill_active && (issue_cnt != NWORDS);
  assign ret_fire     = fill_active && mem_rvalid;
  assign base_n       = ((d_req && !done_d) ? d_addr : i_addr) & ~OFF_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      base      <= '0;
      done_d    <= 1'b0;
    end else begin
      state  <= state_n;
      // One-cycle flag so the still-held d_req is not re-granted as a second write
      done_d <= (state == WRITE);
      if (state == IDLE) begin
        issue_cnt <= '0;
        ret_cnt   <= '0;
        base      <= base_n;
      end else begin
        if (issue_active) issue_cnt <= issue_cnt + 1'b1;
        if (ret_fire)     ret_cnt   <= ret_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_n     = state;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_fill_we   = 1'b0;
    i_fill_addr = '0;
    i_fill_data = '0;
    d_fill_we   = 1'b0;
    d_fill_addr = '0;
    d_fill_data = '0;
    case (state)
      IDLE: begin
        if (d_req && !done_d) state_n = d_wr ? WRITE : FILL_D;
        else if (i_req)       state_n = FILL_I;
      end
      FILL_I, FILL_D: begin
        if (issue_active) begin
          mem_en   = 1'b1;
          mem_addr = base + 16'({issue_cnt, 1'b0});
        end
        if (ret_fire) begin
          if (state == FILL_I) begin
            i_fill_we   = 1'b1;
            i_fill_addr = base + 16'({ret_cnt, 1'b0});
            i_fill_data = mem_rdata;
          end else begin
            d_fill_we   = 1'b1;
            d_fill_addr = base + 16'({ret_cnt, 1'b0});
            d_fill_data = mem_rdata;
          end
          if (ret_cnt == LAST) state_n = IDLE;
        end
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign i_stall = i_req | (state == FILL_I);
  assign d_stall = (d_req & ~done_d) | (state == FILL_D) | (state == WRITE);

`ifdef ARB_PERF_COUNTERS_EN
  logic [15:0] i_cnt_q, d_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
    end else if (state == IDLE) begin
      if (state_n == FILL_I && i_cnt_q != 16'hFFFF) i_cnt_q <= i_cnt_q + 16'd1;
      if (state_n == FILL_D && d_cnt_q != 16'hFFFF) d_cnt_q <= d_cnt_q + 16'd1;
    end
  end

  assign i_miss_cnt = i_cnt_q;
  assign d_miss_cnt = d_cnt_q;
`else
  assign i_miss_cnt = 16'h0000;
  assign d_miss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected memory accesses and fill strobes are queued by the stimulus
// and popped by an independent negedge monitor; a behavioural pipelined memory returns addr ^ 16'hA5A5.
module tb_mem_arbiter;
  localparam int L = 4;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_stall, d_stall, i_fill_we, d_fill_we;
  logic [15:0] i_fill_addr, d_fill_addr, i_fill_data, d_fill_data;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;
  logic [15:0] i_miss_cnt, d_miss_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.MEM_LATENCY(L), .WORDS_PER_BLOCK(W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_stall(i_stall), .d_stall(d_stall),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_addr(i_fill_addr), .d_fill_addr(d_fill_addr),
    .i_fill_data(i_fill_data), .d_fill_data(d_fill_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .i_miss_cnt(i_miss_cnt), .d_miss_cnt(d_miss_cnt)
  );

  // Pipelined memory: a read issued in cycle n returns in cycle n+L; never reset, so aborted fills leave stale returns
  logic        rv_s [L];
  logic [15:0] ra_s [L];
  logic        inj;

  initial begin
    for (int i = 0; i < L; i++) begin
      rv_s[i] = 1'b0;
      ra_s[i] = 16'h0;
    end
  end

  always @(posedge clk) begin
    rv_s[0] <= mem_en & ~mem_wr;
    ra_s[0] <= mem_addr;
    for (int i = 1; i < L; i++) begin
      rv_s[i] <= rv_s[i-1];
      ra_s[i] <= ra_s[i-1];
    end
  end

  assign mem_rvalid = rv_s[L-1] | inj;
  assign mem_rdata  = inj ? 16'h1234 : (ra_s[L-1] ^ 16'hA5A5);

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [31:0] cyc;
  } mem_ev_t;

  typedef struct packed {
    logic        port_d;
    logic [15:0] addr;
    logic [15:0] data;
    logic [31:0] cyc;
  } fill_ev_t;

  mem_ev_t  mem_q[$];
  fill_ev_t fill_q[$];
  mem_ev_t  me;
  fill_ev_t fe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_reads(input logic [15:0] base, input int c1, input int n);
    for (int k = 0; k < n; k++)
      mem_q.push_back(mem_ev_t'{wr: 1'b0, addr: base + 16'(2 * k), data: 16'h0, cyc: 32'(c1 + k)});
  endtask

  task automatic push_fills(input logic port_d, input logic [15:0] base, input int c1, input int n);
    logic [15:0] a;
    for (int k = 0; k < n; k++) begin
      a = base + 16'(2 * k);
      fill_q.push_back(fill_ev_t'{port_d: port_d, addr: a, data: a ^ 16'hA5A5, cyc: 32'(c1 + k)});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every memory access and fill strobe must match the head of its queue
  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_q.size() == 0) begin
        chk("mem_unexpected_access", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        me = mem_q.pop_front();
        chk("mem_wr", 32'(mem_wr), 32'(me.wr));
        chk("mem_addr", 32'(mem_addr), 32'(me.addr));
        if (me.wr) chk("mem_wdata", 32'(mem_wdata), 32'(me.data));
        chk("mem_cycle", 32'(cyc), me.cyc);
      end
    end
    if (i_fill_we === 1'b1 || d_fill_we === 1'b1) begin
      chk("fill_both_ports", 32'(i_fill_we & d_fill_we), 32'h0);
      if (fill_q.size() == 0) begin
        chk("fill_unexpected", {16'h0, i_fill_addr | d_fill_addr}, 32'hFFFF_FFFF);
      end else begin
        fe = fill_q.pop_front();
        chk("fill_port", 32'(d_fill_we), 32'(fe.port_d));
        chk("fill_addr", 32'(fe.port_d ? d_fill_addr : i_fill_addr), 32'(fe.addr));
        chk("fill_data", 32'(fe.port_d ? d_fill_data : i_fill_data), 32'(fe.data));
        chk("fill_cycle", 32'(cyc), fe.cyc);
      end
    end
  end

  int c0;

  initial begin
    rst = 1'b1; inj = 1'b0;
    i_req = 1'b0; i_addr = 16'h0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;

    // Reset state: outputs 0, stall follows the request
    tick(2);
    i_req = 1'b1;
    @(negedge clk);
    chk("rst_i_stall", 32'(i_stall), 32'h1);
    chk("rst_d_stall", 32'(d_stall), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_fill_we", 32'({i_fill_we, d_fill_we}), 32'h0);
    chk("rst_fill_addr", 32'(i_fill_addr | d_fill_addr), 32'h0);
    chk("rst_cnts", {i_miss_cnt, d_miss_cnt}, 32'h0);
    i_req = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(2);

    // Stray mem_rvalid while idle is ignored
    inj = 1'b1;
    @(negedge clk);
    chk("idle_rv_i_fill_we", 32'(i_fill_we), 32'h0);
    chk("idle_rv_d_fill_we", 32'(d_fill_we), 32'h0);
    chk("idle_rv_fill_data", 32'(i_fill_data | d_fill_data), 32'h0);
    tick(1);
    inj = 1'b0;
    tick(1);

    // Reset at cycle 6 of an i-fill: 6 issues, 2 returns, stale returns afterwards ignored
    c0 = cyc;
    i_addr = 16'h0300; i_req = 1'b1;
    push_reads(16'h0300, c0 + 1, 6);
    push_fills(1'b0, 16'h0300, c0 + 5, 2);
    tick(6);
    rst = 1'b1;
    tick(1);
    rst = 1'b0; i_req = 1'b0;
    @(negedge clk);
    chk("abort_i_fill_we", 32'(i_fill_we), 32'h0);
    chk("abort_mem_en", 32'(mem_en), 32'h0);
    chk("abort_i_stall", 32'(i_stall), 32'h0);
    tick(8);

    // i-miss at 0x0136
    c0 = cyc;
    i_addr = 16'h0136; i_req = 1'b1;
    push_reads(16'h0130, c0 + 1, W);
    push_fills(1'b0, 16'h0130, c0 + 1 + L, W);
    @(negedge clk);
    chk("t1_i_stall_req", 32'(i_stall), 32'h1);
    tick(12);
    @(negedge clk);
    chk("t1_i_stall_busy", 32'(i_stall), 32'h1);
    tick(1);
    i_req = 1'b0;
    @(negedge clk);
    chk("t1_i_stall_done", 32'(i_stall), 32'h0);
    chk("t1_mem_en_idle", 32'(mem_en), 32'h0);
    tick(2);

    // Simultaneous d read 0x2004 and i-miss 0x1008: d first, i granted in the first idle cycle
    c0 = cyc;
    d_addr = 16'h2004; d_wr = 1'b0; d_req = 1'b1;
    i_addr = 16'h1008; i_req = 1'b1;
    push_reads(16'h2000, c0 + 1, W);
    push_fills(1'b1, 16'h2000, c0 + 1 + L, W);
    push_reads(16'h1000, c0 + 10 + L, W);
    push_fills(1'b0, 16'h1000, c0 + 10 + 2 * L, W);
    tick(9 + L);
    d_req = 1'b0;
    @(negedge clk);
    chk("t2_i_stall_gap", 32'(i_stall), 32'h1);
    chk("t2_d_stall_done", 32'(d_stall), 32'h0);
    tick(9 + L);
    i_req = 1'b0;
    @(negedge clk);
    chk("t2_i_stall_done", 32'(i_stall), 32'h0);
    tick(2);

    // Write-through 0xBEEF to 0x4002
    c0 = cyc;
    d_addr = 16'h4002; d_wdata = 16'hBEEF; d_wr = 1'b1; d_req = 1'b1;
    mem_q.push_back(mem_ev_t'{wr: 1'b1, addr: 16'h4002, data: 16'hBEEF, cyc: 32'(c0 + 1)});
    tick(1);
    @(negedge clk);
    chk("t3_d_stall_busy", 32'(d_stall), 32'h1);
    tick(1);
    @(negedge clk);
    chk("t3_d_stall_low", 32'(d_stall), 32'h0);
    chk("t3_mem_en_idle", 32'(mem_en), 32'h0);
    d_req = 1'b0; d_wr = 1'b0;
    tick(3);

    // One more i-miss and one more d-miss for the counters
    c0 = cyc;
    i_addr = 16'h0500; i_req = 1'b1;
    push_reads(16'h0500, c0 + 1, W);
    push_fills(1'b0, 16'h0500, c0 + 1 + L, W);
    tick(9 + L);
    i_req = 1'b0;
    tick(1);
    c0 = cyc;
    d_addr = 16'h301E; d_req = 1'b1;
    push_reads(16'h3010, c0 + 1, W);
    push_fills(1'b1, 16'h3010, c0 + 1 + L, W);
    tick(9 + L);
    d_req = 1'b0;
    @(negedge clk);
    chk("t6_d_stall_done", 32'(d_stall), 32'h0);
    tick(2);

`ifdef ARB_PERF_COUNTERS_EN
    chk("i_miss_cnt", 32'(i_miss_cnt), 32'd3);
    chk("d_miss_cnt", 32'(d_miss_cnt), 32'd2);
`else
    chk("i_miss_cnt", 32'(i_miss_cnt), 32'd0);
    chk("d_miss_cnt", 32'(d_miss_cnt), 32'd0);
`endif

    tick(3);
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
    chk("fill_q_drained", 32'(fill_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
